// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: drives ld/clr of every pipeline register for
// load-use stalls, taken-branch flushes and multi-cycle memory waits. Optional macro: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    output logic                  pc_ld,
    output logic                  ifid_ld,
    output logic                  idex_ld,
    output logic                  exmem_ld,
    output logic                  memwb_ld,
    output logic                  ifid_clr,
    output logic                  idex_clr,
    output logic                  memwb_clr,
    output logic                  mem_stall
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count,
    output logic [31:0]           bubble_count
`endif
);

    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam bit MULTI_CYCLE = (MEM_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LATENCY > 1) ? CNT_W'(MEM_LATENCY - 2) : '0;

    typedef enum logic {RUN, WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             flush;
    logic             bubble;

    // cnt counts remaining stall cycles after the current one; the cycle with cnt==0 in WAIT is the final MEM cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && MULTI_CYCLE) begin
                    mem_stall = 1'b1;
                    state_d   = WAIT;
                    cnt_d     = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // A memory stall masks both flush and bubble; they re-evaluate once the held stages advance.
    assign flush  = branch_taken && !mem_stall;
    assign bubble = load_use && !mem_stall && !branch_taken;

    assign pc_ld     = !mem_stall && !bubble;
    assign ifid_ld   = !mem_stall && !bubble;
    assign idex_ld   = !mem_stall;
    assign exmem_ld  = !mem_stall;
    assign memwb_ld  = 1'b1;
    assign ifid_clr  = flush;
    assign idex_clr  = flush || bubble;
    assign memwb_clr = mem_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q, bubble_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            if (mem_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (flush)     flush_count_q  <= flush_count_q + 32'd1;
            if (bubble)    bubble_count_q <= bubble_count_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against
// a reference model that tracks how many cycles the current memory access still occupies MEM.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int ML = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, branch_taken, mem_req;
    logic          pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;
    logic          ifid_clr, idex_clr, memwb_clr, mem_stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles, flush_count, bubble_count;
`endif

    hazard_ctrl #(.REG_ADDR_W(AW), .MEM_LATENCY(ML)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_req(mem_req),
        .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld), .exmem_ld(exmem_ld), .memwb_ld(memwb_ld),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr), .memwb_clr(memwb_clr), .mem_stall(mem_stall)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count), .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    // Cycles left in the current memory access including the present one; 0 means MEM is idle.
    int busy = 0;
    int m_stall = 0, m_flush = 0, m_bubble = 0;
    int seen_stall = 0;

    task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic u1,
                         input logic u2, input logic [AW-1:0] rd, input logic mr,
                         input logic br, input logic mq);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; branch_taken = br; mem_req = mq;
    endtask

    task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at negedge with inputs already driven; checks this cycle, then advances the model.
    task automatic cyc(input string tag);
        logic        stall, lu;
        logic [8:0]  exp_v, got_v;
        #1;
        stall = (busy == 0) ? (mem_req && ML > 1) : (busy > 1);
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        // order: pc ifid idex exmem memwb ld, ifid idex memwb clr, mem_stall
        if (stall)             exp_v = 9'b00001_001_1;
        else if (branch_taken) exp_v = 9'b11111_110_0;
        else if (lu)           exp_v = 9'b00111_010_0;
        else                   exp_v = 9'b11111_000_0;
        got_v = {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_clr, idex_clr, memwb_clr, mem_stall};
        $display("cyc %-10s rst=%0b req=%0b br=%0b lu=%0b out=%b", tag, rst, mem_req, branch_taken, lu, got_v);
        compare(tag, 32'(got_v), 32'(exp_v));
`ifdef HAZARD_PERF_CNT_EN
        compare({tag, "_stc"}, stall_cycles, 32'(m_stall));
        compare({tag, "_flc"}, flush_count, 32'(m_flush));
        compare({tag, "_bbc"}, bubble_count, 32'(m_bubble));
`endif
        if (mem_stall) seen_stall++;
        if (!rst) begin
            if (stall) m_stall++;
            else if (branch_taken) m_flush++;
            else if (lu) m_bubble++;
            if (busy == 0) begin
                if (stall) busy = ML - 1;
            end else begin
                busy--;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        busy = 0; m_stall = 0; m_flush = 0; m_bubble = 0;
        cyc("reset");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        cyc("idle");

        // Reset while waiting on memory: stall drops immediately and stays gone.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cyc("mwait0");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        busy = 0; m_stall = 0; m_flush = 0; m_bubble = 0;
        #1;
        compare("rst_async", 32'(mem_stall), 32'd0);
        cyc("rst_mid");
        rst = 1'b0;
        cyc("post_rst");

        // Load-use on rs2, then the load has left EX.
        drive(0, 5, 0, 1, 5, 1, 0, 0);
        cyc("lu_rs2");
        drive(0, 5, 0, 1, 5, 0, 0, 0);
        cyc("lu_done");

        // Destination x0 never creates a hazard.
        drive(0, 0, 1, 0, 0, 1, 0, 0);
        cyc("x0");

        // Branch outranks load-use.
        drive(7, 0, 1, 0, 7, 1, 1, 0);
        cyc("br_lu");

        // Held mem_req: two stalls, one advance, then a fresh access stalls again.
        seen_stall = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc("mem_held");
        compare("mem_stall_cnt", 32'(seen_stall), 32'd4);

        // Branch during a memory stall only flushes after the stall.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        cyc("st_br0");
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        cyc("st_br1");
        cyc("st_br_flush");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("st_br_idle");
`ifdef HAZARD_PERF_CNT_EN
        compare("perf_stall", stall_cycles, 32'd2);
        compare("perf_flush", flush_count, 32'd1);
`endif

        // Random traffic with small register ranges so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            drive(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), AW'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 99) == 0) do_reset();
            else cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage core.
- Sits directly upstream of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and drives their ld (load enable) and clr (synchronous clear) inputs.
- Handles three hazards: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits. The memory wait is tracked by an internal FSM.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MEM_LATENCY, 3, total cycles a load/store occupies the MEM stage (>=1); 1 means no memory stall.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  REG_ADDR_W  source reg 1 of instruction in ID.
- id_rs2  in  REG_ADDR_W  source reg 2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_ADDR_W  destination reg of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch/jump.
- mem_req  in  1  MEM instruction is a load or store.
- pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld  out  1 each  load enables.
- ifid_clr, idex_clr, memwb_clr  out  1 each  synchronous clears (register gives clr priority over ld).
- mem_stall  out  1  memory wait active this cycle.

Behaviour:
- State: FSM {RUN, WAIT} plus down-counter cnt, width clog2(MEM_LATENCY) (min 1).
- Reset (async, rst=1): state=RUN, cnt=0.
- All outputs are combinational from state, cnt and inputs. Default: every ld=1, every clr=0, mem_stall=0.
- mem_stall is asserted when:
  - RUN and mem_req=1 and MEM_LATENCY>1; or
  - WAIT and cnt!=0.
- FSM transitions:
  - RUN, mem_req=1, MEM_LATENCY>1 -> WAIT, cnt=MEM_LATENCY-2.
  - WAIT, cnt!=0 -> cnt-1.
  - WAIT, cnt==0 -> RUN. This is the final MEM cycle: no stall, pipeline advances, mem_req ignored this cycle.
  - Net effect: MEM_LATENCY-1 stall cycles per memory access. Back-to-back memory instructions each get the full wait.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Output priority, highest first:
  1. mem_stall: pc_ld=ifid_ld=idex_ld=exmem_ld=0, memwb_ld=1, memwb_clr=1 (bubble into WB). All other clr=0. branch_taken and load_use are ignored; they re-evaluate when the stall ends because EX/ID contents are held.
  2. branch_taken: ifid_clr=1, idex_clr=1, all ld=1 (PC loads target). load_use is ignored because the ID instruction is squashed.
  3. load_use: pc_ld=0, ifid_ld=0, idex_clr=1 (bubble into EX), exmem_ld=memwb_ld=1. Exactly one bubble cycle, since the load then leaves EX.
- Register x0 (ex_rd==0) never triggers load_use.
- rst asserted mid-WAIT: FSM returns to RUN immediately; no residual stall after rst deasserts.
- MEM_LATENCY==1: FSM never leaves RUN; mem_stall is constant 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0], flush_count[31:0] and bubble_count[31:0], all reset to 0.
  - stall_cycles increments on each cycle with mem_stall=1.
  - flush_count increments on each cycle with priority-2 active.
  - bubble_count increments on each cycle with priority-3 active.
  - All three wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-WAIT (MEM_LATENCY=3, mem_req=1, rst asserted one cycle later) -> state RUN, mem_stall=0 immediately, all ld=1 after release.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle pc_ld=0, ifid_ld=0, idex_clr=1; next cycle (ex_mem_read=0) all ld=1.
- ex_rd=0, id_rs1=0, ex_mem_read=1, id_use_rs1=1 -> no stall, all ld=1, all clr=0.
- branch_taken=1 together with load_use=1 -> ifid_clr=1, idex_clr=1, pc_ld=1, ifid_ld=1.
- MEM_LATENCY=3, mem_req=1 held -> mem_stall=1 for exactly 2 cycles with memwb_clr=1 and exmem_ld=0, then 1 advance cycle. A second mem_req afterwards -> another 2 stall cycles.
- mem_stall with branch_taken=1 -> ifid_clr=0 and idex_clr=0 during the stall; flush fires in the first cycle after the stall. With HAZARD_PERF_CNT_EN defined: stall_cycles=2 and flush_count=1.
